// File: rtl/vme_io_pkg.sv
// rtl/vme_io_pkg.sv - register map, tag layout and shared helpers for vme_io_regs
package vme_io_pkg;

  localparam logic [4:0] A_FIFO      = 5'd0;
  localparam logic [4:0] A_STATUS    = 5'd1;
  localparam logic [4:0] A_FIFO_CLR  = 5'd2;
  localparam logic [4:0] A_SCRATCH   = 5'd3;
  localparam logic [4:0] A_LATCH     = 5'd4;
  localparam logic [4:0] A_LATCH_CLR = 5'd5;
  localparam logic [4:0] A_LEVEL     = 5'd6;
  localparam logic [4:0] A_PULSE     = 5'd7;
  localparam logic [4:0] A_PW        = 5'd8;
  localparam logic [4:0] A_SEL       = 5'd9;
  localparam logic [4:0] A_COUNT     = 5'd10;
  localparam logic [4:0] A_CNT_CLR   = 5'd11;

  localparam int TAG_W        = 25;
  localparam int TAG_ENC_LSB  = 0;
  localparam int TAG_SNC_LSB  = 14;
  localparam int TAG_LOCK_BIT = 24;

  localparam logic [31:0] RD_DEFAULT = 32'hFEFE_FEFE;

  function automatic logic [TAG_W-1:0] pack_tag(input logic lock, input logic [9:0] snc,
                                                input logic [13:0] enc);
    logic [TAG_W-1:0] t;
    t = '0;
    t[TAG_ENC_LSB +: 14] = enc;
    t[TAG_SNC_LSB +: 10] = snc;
    t[TAG_LOCK_BIT]      = lock;
    return t;
  endfunction

endpackage

// File: rtl/vme_io_regs_if.sv
// rtl/vme_io_regs_if.sv - CPLD VME strobe bus (strobes, address, acknowledge)
interface vme_io_regs_if;
  logic       FRS;
  logic       FWS;
  logic [4:0] FA;
  logic       FDTACK;

  modport master (output FRS, output FWS, output FA, input FDTACK);
  modport slave  (input FRS, input FWS, input FA, output FDTACK);
endinterface

// File: rtl/async_input_sync.sv
// rtl/async_input_sync.sv - two-flop synchroniser plus output register, 3 cycles latency
module async_input_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);
  logic [W-1:0] meta_q, sync_q, out_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
      out_q  <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      out_q  <= sync_q;
    end
  end

  assign sync_o = out_q;
endmodule

// File: rtl/vme_io_regs_tag_fifo.sv
// rtl/vme_io_regs_tag_fifo.sv - tag_fifo: synchronous FIFO with count, flags, sticky overflow, clear
module tag_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 25
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
      if (push_i && !do_push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/vme_io_regs.sv
// rtl/vme_io_regs.sv - VME-mapped NIM I/O registers: input latch, edge counters,
// level/pulse outputs and TRIG2 event-tag FIFO
module vme_io_regs
  import vme_io_pkg::*;
#(
  parameter int NCH        = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic             SYSCLK,
  input  logic             RST_N,
  input  logic [NCH-1:0]   NIM_IN,
  output logic [NCH-1:0]   NIM_OUT,
  input  logic             TRIG2,
  input  logic [13:0]      ENC,
  input  logic [9:0]       SNC,
  input  logic             LOCK,
  vme_io_regs_if.slave     bus,
  inout  wire  [31:0]      DATA
);
  localparam int SW  = NCH + 3;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  logic [SW-1:0]    sync_s, prev_q, rise;
  logic [NCH-1:0]   nim_sync, nim_rise;
  logic             rd_stb, wr_stb, trig_rise, frs_dly, fws_dly, data_oe;
  logic [4:0]       fa_q;
  logic [31:0]      wdata_q, rdata_q, rd_mux_d;
  logic             fdtack_q, trig_q;
  logic [TAG_W-1:0] tag_q, fifo_dout;
  logic [FCW-1:0]   fifo_count;
  logic             fifo_full, fifo_empty, fifo_ovf;
  logic [31:0]      scratch_q;
  logic [NCH-1:0]   level_q, latch_q, latch_d, pulse_on;
  logic [15:0]      pw_q, pw_eff;
  logic [4:0]       sel_q;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [15:0]      pcnt_q [NCH];
  logic [CNT_W-1:0] cnt_sel;
  logic             wr_scratch, wr_level, wr_pw, wr_sel, pulse_go;
  logic             clr_fifo, clr_latch, clr_cnt, do_pop;

  async_input_sync #(.W(SW)) u_sync (
    .clk_i  (SYSCLK),
    .rst_ni (RST_N),
    .async_i({TRIG2, bus.FWS, bus.FRS, NIM_IN}),
    .sync_o (sync_s)
  );

  assign rise      = sync_s & ~prev_q;
  assign nim_sync  = sync_s[NCH-1:0];
  assign nim_rise  = rise[NCH-1:0];
  assign rd_stb    = rise[NCH];
  assign wr_stb    = rise[NCH+1];
  assign trig_rise = rise[NCH+2];
  assign frs_dly   = prev_q[NCH];
  assign fws_dly   = prev_q[NCH+1];

  assign wr_scratch = wr_stb && (fa_q == A_SCRATCH);
  assign wr_level   = wr_stb && (fa_q == A_LEVEL);
  assign wr_pw      = wr_stb && (fa_q == A_PW);
  assign wr_sel     = wr_stb && (fa_q == A_SEL);
  assign pulse_go   = wr_stb && (fa_q == A_PULSE);
  assign clr_fifo   = wr_stb && (fa_q == A_FIFO_CLR);
  assign clr_latch  = wr_stb && (fa_q == A_LATCH_CLR);
  assign clr_cnt    = wr_stb && (fa_q == A_CNT_CLR);
  assign do_pop     = rd_stb && (fa_q == A_FIFO) && !fifo_empty;

  tag_fifo #(.DEPTH(FIFO_DEPTH), .W(TAG_W)) u_tag_fifo (
    .clk_i  (SYSCLK),
    .rst_ni (RST_N),
    .clr_i  (clr_fifo),
    .push_i (trig_q),
    .pop_i  (do_pop),
    .din_i  (tag_q),
    .dout_o (fifo_dout),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .ovf_o  (fifo_ovf)
  );

  // Bus-side timing: acknowledge follows the delayed synced strobe by one cycle
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_q   <= '0;
      fa_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fdtack_q <= 1'b1;
      trig_q   <= 1'b0;
      tag_q    <= '0;
    end else begin
      prev_q   <= sync_s;
      fa_q     <= bus.FA;
      wdata_q  <= DATA;
      fdtack_q <= ~(frs_dly | fws_dly);
      trig_q   <= trig_rise;
      tag_q    <= pack_tag(LOCK, SNC, ENC);
      if (rd_stb) rdata_q <= rd_mux_d;
    end
  end

  assign data_oe    = frs_dly;
  assign DATA       = data_oe ? rdata_q : 32'bz;
  assign bus.FDTACK = fdtack_q;

  assign latch_d = clr_latch ? '0 : (latch_q | nim_sync);
  assign pw_eff  = (pw_q == 16'd0) ? 16'd1 : pw_q;

  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      scratch_q <= '0;
      level_q   <= '0;
      pw_q      <= '0;
      sel_q     <= '0;
      latch_q   <= '0;
    end else begin
      if (wr_scratch) scratch_q <= wdata_q;
      if (wr_level)   level_q   <= wdata_q[NCH-1:0];
      if (wr_pw)      pw_q      <= wdata_q[15:0];
      if (wr_sel)     sel_q     <= wdata_q[4:0];
      latch_q <= latch_d;
    end
  end

  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        pcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr_cnt)          cnt_q[i] <= '0;
        else if (nim_rise[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        if (pulse_go && wdata_q[i])  pcnt_q[i] <= pw_eff;
        else if (pcnt_q[i] != 16'd0) pcnt_q[i] <= pcnt_q[i] - 16'd1;
      end
    end
  end

  always_comb begin
    pulse_on = '0;
    cnt_sel  = cnt_q[0];
    for (int i = 0; i < NCH; i++) begin
      pulse_on[i] = (pcnt_q[i] != 16'd0);
      if (sel_q == 5'(i)) cnt_sel = cnt_q[i];
    end
  end

  assign NIM_OUT = level_q | pulse_on;

  always_comb begin
    rd_mux_d = RD_DEFAULT;
    case (fa_q)
      A_FIFO:      rd_mux_d = fifo_empty ? 32'd0 : {1'b1, 6'd0, fifo_dout};
      A_STATUS:    rd_mux_d = {fifo_ovf, fifo_full, fifo_empty, 13'd0, 16'(fifo_count)};
      A_SCRATCH:   rd_mux_d = scratch_q;
      A_LATCH:     rd_mux_d = 32'(latch_q);
      A_LEVEL:     rd_mux_d = 32'(level_q);
      A_PW:        rd_mux_d = {16'd0, pw_q};
      A_SEL:       rd_mux_d = {27'd0, sel_q};
      A_COUNT:     rd_mux_d = 32'(cnt_sel);
      A_FIFO_CLR, A_LATCH_CLR, A_PULSE, A_CNT_CLR: rd_mux_d = 32'd0;
      default:     rd_mux_d = RD_DEFAULT;
    endcase
  end
endmodule

// File: tb/tb_vme_io_regs.sv
// tb/tb_vme_io_regs.sv - self-checking bench for vme_io_regs
module tb_vme_io_regs;
  localparam int NCH   = 16;
  localparam int DEPTH = 16;
  localparam int CW    = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NCH-1:0]  nim_in = '0;
  logic [NCH-1:0]  nim_out;
  logic            trig2 = 1'b0;
  logic [13:0]     enc = '0;
  logic [9:0]      snc = '0;
  logic            lock = 1'b0;
  logic            tb_oe = 1'b0;
  logic [31:0]     tb_dout = '0;
  wire  [31:0]     data_w;

  assign data_w = tb_oe ? tb_dout : 32'bz;

  vme_io_regs_if bus();

  vme_io_regs #(.NCH(NCH), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .SYSCLK (clk),
    .RST_N  (rst_n),
    .NIM_IN (nim_in),
    .NIM_OUT(nim_out),
    .TRIG2  (trig2),
    .ENC    (enc),
    .SNC    (snc),
    .LOCK   (lock),
    .bus    (bus),
    .DATA   (data_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int hi0 = 0, hi1 = 0, lo15 = 0;

  always @(negedge clk) begin
    if (nim_out[0])   hi0++;
    if (nim_out[1])   hi1++;
    if (!nim_out[15]) lo15++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tag_word(input logic l, input logic [9:0] s, input logic [13:0] e);
    return {1'b1, 6'd0, l, s, e};
  endfunction

  task automatic wait_dtack(input logic lvl, input string name);
    int n;
    n = 0;
    while (bus.FDTACK !== lvl && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.FDTACK !== lvl) check(name, 32'(bus.FDTACK), 32'(lvl));
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus.FA = a; tb_dout = d; tb_oe = 1'b1;
    @(negedge clk);
    bus.FWS = 1'b1;
    wait_dtack(1'b0, "wr_ack_timeout");
    bus.FWS = 1'b0;
    wait_dtack(1'b1, "wr_release_timeout");
    tb_oe = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    bus.FA = a;
    @(negedge clk);
    bus.FRS = 1'b1;
    wait_dtack(1'b0, "rd_ack_timeout");
    d = data_w;
    bus.FRS = 1'b0;
    wait_dtack(1'b1, "rd_release_timeout");
    @(negedge clk);
  endtask

  task automatic trigger(input logic l, input logic [9:0] s, input logic [13:0] e);
    lock = l; snc = s; enc = e;
    @(negedge clk);
    trig2 = 1'b1;
    repeat (2) @(negedge clk);
    trig2 = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic nim_pulse(input int ch);
    nim_in[ch] = 1'b1;
    repeat (2) @(negedge clk);
    nim_in[ch] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.FRS = 1'b0; bus.FWS = 1'b0; trig2 = 1'b0; nim_in = '0; tb_oe = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[20];

  logic [31:0] rd;
  logic [31:0] m_scratch;
  logic [24:0] m_q[$];
  bit          m_ovf;
  int          m_cnt[NCH];
  logic [NCH-1:0] m_latch;
  int a0, a1, a15;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.FRS = 1'b0; bus.FWS = 1'b0; bus.FA = '0;
    vecs[0]  = '{1'b0, 5'd1,  32'd0,         32'h2000_0000};
    vecs[1]  = '{1'b0, 5'd0,  32'd0,         32'h0000_0000};
    vecs[2]  = '{1'b0, 5'd20, 32'd0,         32'hFEFE_FEFE};
    vecs[3]  = '{1'b0, 5'd31, 32'd0,         32'hFEFE_FEFE};
    vecs[4]  = '{1'b0, 5'd3,  32'd0,         32'h0000_0000};
    vecs[5]  = '{1'b1, 5'd3,  32'hA5A5_5A5A, 32'd0};
    vecs[6]  = '{1'b0, 5'd3,  32'd0,         32'hA5A5_5A5A};
    vecs[7]  = '{1'b1, 5'd8,  32'h0001_0007, 32'd0};
    vecs[8]  = '{1'b0, 5'd8,  32'd0,         32'h0000_0007};
    vecs[9]  = '{1'b1, 5'd9,  32'hFFFF_FFE3, 32'd0};
    vecs[10] = '{1'b0, 5'd9,  32'd0,         32'h0000_0003};
    vecs[11] = '{1'b1, 5'd6,  32'hFFFF_FFFF, 32'd0};
    vecs[12] = '{1'b0, 5'd6,  32'd0,         32'h0000_FFFF};
    vecs[13] = '{1'b1, 5'd6,  32'h0000_0000, 32'd0};
    vecs[14] = '{1'b1, 5'd20, 32'h1234_5678, 32'd0};
    vecs[15] = '{1'b0, 5'd3,  32'd0,         32'hA5A5_5A5A};
    vecs[16] = '{1'b0, 5'd4,  32'd0,         32'h0000_0000};
    vecs[17] = '{1'b0, 5'd10, 32'd0,         32'h0000_0000};
    vecs[18] = '{1'b0, 5'd7,  32'd0,         32'h0000_0000};
    vecs[19] = '{1'b0, 5'd12, 32'd0,         32'hFEFE_FEFE};

    repeat (2) @(negedge clk);
    check("reset_fdtack", 32'(bus.FDTACK), 32'd1);
    check("reset_data_oe", 32'(dut.data_oe), 32'd0);
    check("reset_nim_out", 32'(nim_out), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
      end
    end
    repeat (3) @(negedge clk);
    check("idle_fdtack", 32'(bus.FDTACK), 32'd1);

    // Tag FIFO: three tags, pops, empty pop
    for (int i = 0; i < 3; i++) trigger(1'b1, 10'h3A3, 14'(16'h0123 + i));
    bus_read(5'd1, rd); check("tag_status3", rd, 32'h0000_0003);
    bus_read(5'd0, rd); check("tag_pop0_literal", rd, 32'h81E8_C123);
    for (int i = 1; i < 3; i++) begin
      bus_read(5'd0, rd);
      check($sformatf("tag_pop%0d", i), rd, tag_word(1'b1, 10'h3A3, 14'(16'h0123 + i)));
    end
    bus_read(5'd0, rd); check("tag_pop_empty", rd, 32'd0);
    bus_read(5'd1, rd); check("tag_status_empty", rd, 32'h2000_0000);

    // Overflow
    for (int i = 0; i < DEPTH + 2; i++) trigger(1'b0, 10'd0, 14'(i));
    bus_read(5'd1, rd); check("ovf_status", rd, {1'b1, 1'b1, 1'b0, 13'd0, 16'(DEPTH)});
    bus_read(5'd0, rd); check("ovf_first_pop", rd, tag_word(1'b0, 10'd0, 14'd0));
    bus_read(5'd1, rd); check("ovf_after_pop", rd, {1'b1, 1'b0, 1'b0, 13'd0, 16'(DEPTH - 1)});
    bus_write(5'd2, 32'd1);
    bus_read(5'd1, rd); check("fifo_clear", rd, 32'h2000_0000);

    // Pulses
    bus_write(5'd8, 32'd5);
    bus_write(5'd6, 32'h0000_8000);
    a0 = hi0; a1 = hi1; a15 = lo15;
    bus_write(5'd7, 32'h0000_0003);
    repeat (10) @(negedge clk);
    check("pulse_pw5_ch0", 32'(hi0 - a0), 32'd5);
    check("pulse_pw5_ch1", 32'(hi1 - a1), 32'd5);

    bus.FA = 5'd7; tb_dout = 32'h0000_0003; tb_oe = 1'b1;
    @(negedge clk);
    a0 = hi0;
    bus.FWS = 1'b1; @(negedge clk);
    bus.FWS = 1'b0; repeat (2) @(negedge clk);
    bus.FWS = 1'b1; @(negedge clk);
    bus.FWS = 1'b0;
    repeat (20) @(negedge clk);
    tb_oe = 1'b0;
    check("pulse_retrigger", 32'(hi0 - a0), 32'd8);
    check("level15_held", 32'(lo15 - a15), 32'd0);

    bus_write(5'd8, 32'd0);
    a0 = hi0;
    bus_write(5'd7, 32'h0000_0001);
    repeat (4) @(negedge clk);
    check("pulse_pw0", 32'(hi0 - a0), 32'd1);
    bus_write(5'd6, 32'd0);

    // Edge counters and latch
    for (int i = 0; i < 10; i++) nim_pulse(4);
    nim_pulse(0); nim_pulse(0);
    bus_write(5'd9, 32'd4);
    bus_read(5'd10, rd); check("cnt4_10", rd, 32'd10);
    bus_read(5'd4, rd);  check("latch_bit4", rd, 32'h0000_0011);
    bus_write(5'd9, 32'd20);
    bus_read(5'd10, rd); check("cnt_sel_oor", rd, 32'd2);
    bus_write(5'd11, 32'd0);
    bus_write(5'd5, 32'd0);
    bus_write(5'd9, 32'd4);
    bus_read(5'd10, rd); check("cnt_cleared", rd, 32'd0);
    bus_read(5'd4, rd);  check("latch_cleared", rd, 32'd0);
    for (int i = 0; i < 260; i++) nim_pulse(4);
    bus_read(5'd10, rd); check("cnt_wrap", rd, 32'd4);

    // Reset during an active read and pulse
    bus_write(5'd3, 32'h1234_5678);
    bus_write(5'd6, 32'h0000_00FF);
    bus_write(5'd8, 32'd100);
    bus_write(5'd7, 32'h0000_0100);
    bus.FA = 5'd3;
    @(negedge clk);
    bus.FRS = 1'b1;
    wait_dtack(1'b0, "rst_rd_ack_timeout");
    check("rst_rd_data", data_w, 32'h1234_5678);
    check("rst_rd_oe", 32'(dut.data_oe), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_oe", 32'(dut.data_oe), 32'd0);
    check("rst_async_fdtack", 32'(bus.FDTACK), 32'd1);
    check("rst_async_nim_out", 32'(nim_out), 32'd0);
    bus.FRS = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(5'd3, rd); check("post_rst_scratch", rd, 32'd0);
    bus_read(5'd6, rd); check("post_rst_level", rd, 32'd0);
    bus_read(5'd8, rd); check("post_rst_pw", rd, 32'd0);
    bus_read(5'd1, rd); check("post_rst_status", rd, 32'h2000_0000);

    // Randomized traffic against a queue/array reference model
    do_reset();
    m_scratch = '0; m_ovf = 0; m_latch = '0; m_q.delete();
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    for (int it = 0; it < 80; it++) begin
      int op;
      op = $urandom_range(0, 6);
      case (op)
        0: begin
          logic [31:0] w;
          w = $urandom;
          m_scratch = w;
          bus_write(5'd3, w);
          bus_read(5'd3, rd); check("rnd_scratch", rd, m_scratch);
        end
        1, 2: begin
          logic l; logic [9:0] s; logic [13:0] e;
          l = 1'($urandom); s = 10'($urandom); e = 14'($urandom);
          trigger(l, s, e);
          if (m_q.size() < DEPTH) m_q.push_back({l, s, e});
          else m_ovf = 1'b1;
        end
        3: begin
          logic [31:0] exp;
          exp = 32'd0;
          if (m_q.size() > 0) exp = {1'b1, 6'd0, m_q.pop_front()};
          bus_read(5'd0, rd); check("rnd_pop", rd, exp);
        end
        4: begin
          bus_read(5'd1, rd);
          check("rnd_status", rd, {m_ovf, 1'(m_q.size() == DEPTH), 1'(m_q.size() == 0),
                                   13'd0, 16'(m_q.size())});
        end
        5: begin
          int ch;
          ch = $urandom_range(0, NCH - 1);
          nim_pulse(ch);
          m_cnt[ch] = (m_cnt[ch] + 1) % (1 << CW);
          m_latch[ch] = 1'b1;
        end
        default: begin
          int sel;
          sel = $urandom_range(0, 31);
          bus_write(5'd9, 32'(sel));
          bus_read(5'd10, rd);
          check("rnd_counter", rd, 32'((sel < NCH) ? m_cnt[sel] : m_cnt[0]));
          bus_read(5'd4, rd); check("rnd_latch", rd, 32'(m_latch));
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
